// File: rtl/dnn_pkg.sv
// Types and constants shared by the inference datapath and its result collector.
package dnn_pkg;
  localparam int SCORE_W   = 17;
  localparam int DNN_IN_W  = 8;
  localparam int DNN_HID_W = 16;

  // One classified sample. cls is 1 when score1 strictly beats score0.
  typedef struct packed {
    logic [SCORE_W-1:0] score0;
    logic [SCORE_W-1:0] score1;
    logic               cls;
    logic [SCORE_W:0]   margin;
  } dnn_result_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } collector_state_e;
endpackage

// File: rtl/dnn_result_fifo.sv
// Synchronous circular FIFO of classified results; wrap-bit pointers give full/empty.
module dnn_result_fifo
  import dnn_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_clear,
  input  logic                   i_push,
  input  dnn_result_t            i_wr_data,
  input  logic                   i_pop,
  output dnn_result_t            o_rd_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  dnn_result_t r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_push_ok;
  logic        w_pop_ok;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign w_pop_ok  = i_pop & ~o_empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_push_ok = i_push & (~o_full | w_pop_ok);
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok && !i_clear) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end
endmodule

// File: rtl/dnn_result_collector.sv
// Collects out0/out1 score pairs, drops pipeline warm-up samples, classifies and
// queues them for the readout stage, and flags strobe mismatches and overflow.
module dnn_result_collector
  import dnn_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int SKIP    = 2,
  parameter int SCORE_W = dnn_pkg::SCORE_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [SCORE_W-1:0]     out0,
  input  logic [SCORE_W-1:0]     out1,
  input  logic                   out10_ready,
  input  logic                   out11_ready,
  input  logic                   clear,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [SCORE_W-1:0]     res_score0,
  output logic [SCORE_W-1:0]     res_score1,
  output logic                   res_class,
  output logic [SCORE_W:0]       res_margin,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic                   mismatch,
  output logic [7:0]             drop_count,
  output collector_state_e       dbg_state
);
  localparam logic [7:0] SKIP_L = 8'(SKIP);

  collector_state_e r_state;
  collector_state_e w_state_nxt;
  logic [7:0]       r_skip_cnt;
  logic [7:0]       w_skip_nxt;
  logic             w_sample_evt;
  logic             w_one_strobe;
  logic             w_no_strobe;
  logic             w_push_cand;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_ovf_evt;
  logic             w_mis_evt;
  logic [SCORE_W:0] w_diff;
  dnn_result_t      w_entry;
  dnn_result_t      w_head;

  assign w_sample_evt = out10_ready & out11_ready;
  assign w_one_strobe = out10_ready ^ out11_ready;
  assign w_no_strobe  = ~out10_ready & ~out11_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_skip_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_skip_cnt <= w_skip_nxt;
    end
  end

  // Next state: every new burst re-skips SKIP samples while the datapath refills.
  always_comb begin
    w_state_nxt = r_state;
    w_skip_nxt  = r_skip_cnt;
    if (clear || w_no_strobe) begin
      w_state_nxt = IDLE;
      w_skip_nxt  = '0;
    end else if (w_sample_evt) begin
      case (r_state)
        IDLE: begin
          if (SKIP == 0) begin
            w_state_nxt = STREAM;
          end else begin
            w_skip_nxt  = 8'd1;
            w_state_nxt = (SKIP_L == 8'd1) ? STREAM : FILL;
          end
        end
        FILL: begin
          w_skip_nxt = r_skip_cnt + 8'd1;
          if (r_skip_cnt + 8'd1 == SKIP_L) w_state_nxt = STREAM;
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Outputs of the state machine
  always_comb begin
    w_push_cand = 1'b0;
    if (!clear && w_sample_evt)
      w_push_cand = (r_state == STREAM) || ((r_state == IDLE) && (SKIP == 0));
  end

  assign dbg_state = r_state;

  assign w_diff          = {out1[SCORE_W-1], out1} - {out0[SCORE_W-1], out0};
  assign w_entry.score0  = out0;
  assign w_entry.score1  = out1;
  assign w_entry.cls     = ~w_diff[SCORE_W] & (w_diff != '0);
  assign w_entry.margin  = w_diff[SCORE_W] ? -w_diff : w_diff;

  // Readout handshake: the head is transferred on a rising edge where res_valid
  // and res_ready are both high; the head stays stable while res_valid & ~res_ready.
  assign w_pop = res_valid & res_ready;

  dnn_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (clear),
    .i_push    (w_push_cand),
    .i_wr_data (w_entry),
    .i_pop     (w_pop),
    .o_rd_data (w_head),
    .o_count   (fifo_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign res_valid  = ~w_empty;
  assign res_score0 = w_head.score0;
  assign res_score1 = w_head.score1;
  assign res_class  = w_head.cls;
  assign res_margin = w_head.margin;

  assign w_ovf_evt = w_push_cand & w_full & ~w_pop;
  assign w_mis_evt = ~clear & w_one_strobe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      mismatch   <= 1'b0;
      drop_count <= '0;
    end else if (clear) begin
      overflow   <= 1'b0;
      mismatch   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (w_ovf_evt) overflow <= 1'b1;
      if (w_mis_evt) mismatch <= 1'b1;
      if ((w_ovf_evt || w_mis_evt) && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end
endmodule

// File: doc/dnn_result_collector.md
Name: dnn_result_collector

Overview:
- Sits downstream of the 4-4-2 inference datapath and consumes its two signed 17-bit scores, out0 and out1, using their per-output ready strobes.
- Drops pipeline warm-up results and classifies each valid sample as an argmax with a margin.
- Buffers samples in a small FIFO and hands them to a host/readout stage over a valid/ready handshake.
- Flags protocol errors: mismatched ready strobes and overflow.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- SKIP, 2, ready-qualified samples discarded at the start of each burst (pipeline fill of the datapath).
- SCORE_W, 17, width of each incoming score.

Ports:
- clk  in  1  rising-edge clock shared with the datapath.
- rst_n  in  1  asynchronous active-low reset.
- out0  in  SCORE_W  signed score, class 0.
- out1  in  SCORE_W  signed score, class 1.
- out10_ready  in  1  out0 valid strobe.
- out11_ready  in  1  out1 valid strobe.
- clear  in  1  synchronous flush of FIFO, sticky flags and counters.
- res_valid  out  1  head entry available.
- res_ready  in  1  consumer accepts head.
- res_score0  out  SCORE_W  head entry, out0 copy.
- res_score1  out  SCORE_W  head entry, out1 copy.
- res_class  out  1  head entry class: 1 if score1 > score0, else 0 (ties resolve to 0).
- res_margin  out  SCORE_W+1  head entry, unsigned |score1 - score0|.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a sample was dropped because the FIFO was full.
- mismatch  out  1  sticky: exactly one ready strobe was high in a cycle.
- drop_count  out  8  saturating count of samples lost to overflow or mismatch.

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, res_valid=0, data outputs 0, fifo_count=0, overflow=0, mismatch=0, drop_count=0, skip counter=0, state IDLE.
- Sample qualifier: sample_evt = out10_ready & out11_ready.
  - If out10_ready ^ out11_ready: set mismatch, increment drop_count, do not push, do not advance the skip counter.
- Warm-up state machine:
  - IDLE: no strobe seen. First sample_evt goes to FILL and counts as skip #1. If SKIP==0, go directly to STREAM and push that sample.
  - FILL: each sample_evt increments the skip counter and is discarded. When the count reaches SKIP, go to STREAM on that same edge; that discarded sample is the last one dropped.
  - STREAM: each sample_evt is a push candidate.
  - Any cycle with both strobes low, in FILL or STREAM, returns to IDLE and clears the skip counter. Each new burst therefore re-skips.
- Classification, registered at push, 1-cycle latency from strobe to entry:
  - Sign-extend both scores to SCORE_W+1.
  - diff = score1 - score0.
  - class = ~diff[MSB] & (diff != 0).
  - margin = diff[MSB] ? -diff : diff. No saturation is needed; the range fits.
- FIFO:
  - Registered circular buffer. Read and write pointers are $clog2(DEPTH)+1 bits with a wrap bit; full/empty are derived from the wrap bit.
  - res_* outputs are a direct view of the head entry. res_valid = ~empty. Head data is held stable while res_valid & ~res_ready.
  - Pop when res_valid & res_ready.
  - Push when the candidate is present and either ~full, or full and popping in the same cycle. Simultaneous push and pop when full is legal: count is unchanged and no overflow.
  - Simultaneous push and pop when empty: the entry is pushed. res_valid rises the next cycle; no fall-through.
  - Push while full and not popping: candidate is dropped, overflow is set, drop_count increments.
- drop_count saturates at 255.
- clear (synchronous, priority over push/pop): empties the FIFO; zeroes the flags, drop_count and skip counter; state goes to IDLE. A strobe in the clear cycle is ignored.
- Reset asserted mid-burst: everything returns to reset values immediately. The first burst after release re-skips.

Decomposition:
- Shared package dnn_pkg:
  - SCORE_W and the hidden/input width constants shared with the datapath.
  - typedef struct dnn_result_t {score0, score1, class, margin}.
  - typedef enum collector_state_e {IDLE, FILL, STREAM}.
- One sub-module: dnn_result_fifo, a parameterised sync FIFO of dnn_result_t providing count, full and empty.
- Classification and the state machine stay in the top.

Test Plan:
- Warm-up skip: reset, then 5 consecutive strobes with scores (10,20), (1,2), (-5,3), (7,7), (100,-4) -> only the last 3 are queued. Entries: class 1 margin 8; class 0 margin 0; class 0 margin 104. fifo_count=3.
- Burst restart: 3 strobes, 1 idle cycle, 3 strobes, res_ready=1 -> exactly 2 entries emerge (the 3rd of each burst), res_valid never set during a fill.
- Overflow plus simultaneous push/pop:
  - res_ready=0, SKIP+10 strobes -> fifo_count=8, overflow=1, drop_count=2.
  - Then res_ready=1 with strobes continuing -> count stays 8, drop_count unchanged.
- Mismatch: one cycle with out10_ready=1, out11_ready=0 mid-stream -> mismatch=1, drop_count=1, no push; stream continues on following both-high cycles.
- Extremes: out0=-65536, out1=65535 -> class 1, margin 131071. Swapped -> class 0, margin 131071.
- Reset and clear: assert rst_n low asynchronously with 4 entries queued -> all outputs 0 within the same cycle. Repeat with clear -> same result on the next edge, strobe in that cycle discarded.
